// File: rtl/bram_fifo_ctl_if.sv
// Write stream, read stream and block-RAM port bundle for bram_fifo_ctl.
// master = the controller, slave = the surrounding logic (producer, consumer, RAM).
interface bram_fifo_ctl_if #(
    parameter int ADDRESSWIDTH = 6,
    parameter int BITWIDTH     = 1
);
    logic                    wr_valid;
    logic                    wr_ready;
    logic [BITWIDTH-1:0]     wr_data;
    logic                    rd_valid;
    logic                    rd_ready;
    logic [BITWIDTH-1:0]     rd_data;
    logic [ADDRESSWIDTH-1:0] ram_a;
    logic                    ram_we;
    logic [BITWIDTH-1:0]     ram_din;
    logic [ADDRESSWIDTH-1:0] ram_dpra;
    logic                    ram_qdpo_ce;
    logic [BITWIDTH-1:0]     ram_qdpo;
    logic [ADDRESSWIDTH:0]   count;
    logic                    almost_full;

    modport master (
        input  wr_valid, wr_data, rd_ready, ram_qdpo,
        output wr_ready, rd_valid, rd_data, ram_a, ram_we, ram_din,
               ram_dpra, ram_qdpo_ce, count, almost_full
    );

    modport slave (
        output wr_valid, wr_data, rd_ready, ram_qdpo,
        input  wr_ready, rd_valid, rd_data, ram_a, ram_we, ram_din,
               ram_dpra, ram_qdpo_ce, count, almost_full
    );
endinterface

// File: rtl/bram_fifo_ctl.sv
// FWFT valid/ready FIFO controller around a dual-port RAM with registered read; BRAM_FIFO_CTL_AFULL_EN adds almost_full.
// Latency: a word accepted at edge t is presented on rd_data after edge t+1; one word/cycle when streaming.
// Backpressure: wr_ready drops when the RAM holds DEPTH words; RAM read is stalled (ce=0) while the head is not taken.
module bram_fifo_ctl #(
    parameter int ADDRESSWIDTH = 6,
    parameter int BITWIDTH     = 1,
    parameter int DEPTH        = 34,
    parameter int AFULL_THRESH = 30
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    bram_fifo_ctl_if.master bus
);
    localparam logic [ADDRESSWIDTH:0]   FULL_C = (ADDRESSWIDTH+1)'(DEPTH);
    localparam logic [ADDRESSWIDTH:0]   STEP_C = (ADDRESSWIDTH+1)'(1);
    localparam logic [ADDRESSWIDTH-1:0] LAST_C = ADDRESSWIDTH'(DEPTH - 1);
    localparam logic [ADDRESSWIDTH-1:0] PINC_C = ADDRESSWIDTH'(1);

    logic [ADDRESSWIDTH-1:0] wptr;
    logic [ADDRESSWIDTH-1:0] rptr;
    logic [ADDRESSWIDTH:0]   stored;
    logic [ADDRESSWIDTH:0]   stored_nxt;
    logic                    out_valid;
    logic                    out_valid_nxt;
    logic                    active;
    logic                    we;
    logic                    issue;
    logic                    pop;

    assign active          = reset_n && !flush;
    assign bus.wr_ready    = active && (stored != FULL_C);
    assign we              = bus.wr_valid && bus.wr_ready;
    // Refill the output register whenever it is empty or being emptied this cycle.
    assign issue           = active && (stored != '0) && (!out_valid || bus.rd_ready);
    assign pop             = out_valid && bus.rd_ready;

    assign bus.ram_we      = we;
    assign bus.ram_a       = wptr;
    assign bus.ram_din     = BITWIDTH'(bus.wr_data);
    assign bus.ram_dpra    = rptr;
    assign bus.ram_qdpo_ce = issue;
    assign bus.rd_valid    = out_valid;
    assign bus.rd_data     = BITWIDTH'(bus.ram_qdpo);
    assign bus.count       = stored + {{ADDRESSWIDTH{1'b0}}, out_valid};

    always_comb begin
        stored_nxt = stored;
        if (we && !issue)
            stored_nxt = stored + STEP_C;
        else if (issue && !we)
            stored_nxt = stored - STEP_C;
        out_valid_nxt = out_valid;
        if (issue)
            out_valid_nxt = 1'b1;
        else if (pop)
            out_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wptr      <= '0;
            rptr      <= '0;
            stored    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (we)
                wptr <= (wptr == LAST_C) ? '0 : wptr + PINC_C;
            if (issue)
                rptr <= (rptr == LAST_C) ? '0 : rptr + PINC_C;
            stored    <= stored_nxt;
            out_valid <= out_valid_nxt;
        end
    end

`ifdef BRAM_FIFO_CTL_AFULL_EN
    localparam logic [ADDRESSWIDTH:0] AFULL_C = (ADDRESSWIDTH+1)'(AFULL_THRESH);

    logic [ADDRESSWIDTH:0] count_nxt;
    logic                  afull_q;

    // Registered from next-state count so the flag tracks count with no lag.
    assign count_nxt = stored_nxt + {{ADDRESSWIDTH{1'b0}}, out_valid_nxt};

    always_ff @(posedge clk) begin
        if (!reset_n || flush)
            afull_q <= 1'b0;
        else
            afull_q <= (count_nxt >= AFULL_C);
    end

    assign bus.almost_full = afull_q;
`else
    assign bus.almost_full = 1'b0;
`endif
endmodule
